eth_rx_bufwriter: RTL and testbench

- Receive-side stage directly upstream of the Ethernet APB peripheral's RX buffer.
- Consumes a byte stream from the MAC receive interface, already in the `clk` domain, and writes each accepted frame byte-by-byte into the RX frame buffer's write port (port A).
- Publishes the frame length and the `rx_wrote`/`ndiscarded` counters that the peripheral exposes to software and uses for `irqrx`.
- Enforces the one-frame buffer ownership rule: a frame is written only when the previous frame has been consumed (`rx_read == rx_wrote`).

---
 rtl/eth_rx_bufwriter.sv | 200 ++++++++++++++++++++
 tb/tb_eth_rx_bufwriter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_rx_bufwriter.sv
// eth_rx_bufwriter
// Receive-side writer that sits in front of the Ethernet RX frame buffer.
// Takes the MAC byte stream, writes accepted frames into buffer port A,
// and maintains the committed-frame and dropped-frame counters that
// software sees. Only one frame may live in the buffer at a time: a new
// frame is written only when software has consumed the previous one
// (rx_read == rx_wrote), and that check is made on the first byte only.

module eth_rx_bufwriter #(
    parameter int MTU     = 1536,
    parameter int AW      = 32,
    parameter int MIN_LEN = 14
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    input  logic          in_first,
    input  logic          in_last,
    input  logic          in_err,
    input  logic [15:0]   rx_read,
    output logic          buf_we,
    output logic [AW-1:0] buf_addr,
    output logic [7:0]    buf_wdata,
    output logic          receiving,
    output logic [15:0]   rx_size,
    output logic [15:0]   rx_wrote,
    output logic [15:0]   ndiscarded,
    output logic          frame_done
);

    localparam logic [15:0] MTU_W     = 16'(MTU);
    localparam logic [15:0] MIN_LEN_W = 16'(MIN_LEN);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        DROP
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    logic          buf_we_q, buf_we_d;
    logic [AW-1:0] buf_addr_q, buf_addr_d;
    logic [7:0]    buf_wdata_q, buf_wdata_d;
    logic          receiving_q, receiving_d;
    logic [15:0]   rx_size_q, rx_size_d;
    logic [15:0]   rx_wrote_q, rx_wrote_d;
    logic [15:0]   ndiscarded_q, ndiscarded_d;
    logic          frame_done_q, frame_done_d;

    logic          start_eval;
    logic          disc_trunc;
    logic          disc_frame;
    logic          buf_free;
    logic [15:0]   length;

    assign buf_free = (rx_read == rx_wrote_q);
    assign length   = cnt_q + 16'd1;

    // Next-state logic: decide what happens to the current byte, including
    // restarting a frame when a first byte shows up mid-frame or mid-drop.
    // A truncated frame and a one-byte frame arriving together both count
    // as discards, so a commit never lands in the same cycle as a discard.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        buf_we_d     = 1'b0;
        buf_addr_d   = buf_addr_q;
        buf_wdata_d  = buf_wdata_q;
        receiving_d  = receiving_q;
        rx_size_d    = rx_size_q;
        rx_wrote_d   = rx_wrote_q;
        frame_done_d = 1'b0;
        start_eval   = 1'b0;
        disc_trunc   = 1'b0;
        disc_frame   = 1'b0;

        if (in_valid) begin
            case (state_q)
                IDLE: begin
                    start_eval = in_first;
                end
                RECV: begin
                    if (in_first) begin
                        disc_trunc = 1'b1;
                        start_eval = 1'b1;
                    end else if (cnt_q == MTU_W) begin
                        receiving_d = 1'b0;
                        if (in_last) begin
                            disc_frame = 1'b1;
                            state_d    = IDLE;
                        end else begin
                            state_d    = DROP;
                        end
                    end else begin
                        buf_we_d    = 1'b1;
                        buf_addr_d  = AW'(cnt_q);
                        buf_wdata_d = in_data;
                        cnt_d       = length;
                        if (in_last) begin
                            receiving_d = 1'b0;
                            state_d     = IDLE;
                            if (length >= MIN_LEN_W && !in_err) begin
                                rx_size_d    = length;
                                rx_wrote_d   = rx_wrote_q + 16'd1;
                                frame_done_d = 1'b1;
                            end else begin
                                disc_frame   = 1'b1;
                            end
                        end
                    end
                end
                DROP: begin
                    if (in_first) begin
                        disc_trunc = 1'b1;
                        start_eval = 1'b1;
                    end else if (in_last) begin
                        disc_frame = 1'b1;
                        state_d    = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase

            if (start_eval) begin
                if (buf_free) begin
                    buf_we_d    = 1'b1;
                    buf_addr_d  = '0;
                    buf_wdata_d = in_data;
                    cnt_d       = 16'd1;
                    if (in_last) begin
                        receiving_d = 1'b0;
                        state_d     = IDLE;
                        if (MIN_LEN_W <= 16'd1 && !in_err && !disc_trunc) begin
                            rx_size_d    = 16'd1;
                            rx_wrote_d   = rx_wrote_q + 16'd1;
                            frame_done_d = 1'b1;
                        end else begin
                            disc_frame   = 1'b1;
                        end
                    end else begin
                        receiving_d = 1'b1;
                        state_d     = RECV;
                    end
                end else begin
                    receiving_d = 1'b0;
                    cnt_d       = '0;
                    if (in_last) begin
                        disc_frame = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        state_d    = DROP;
                    end
                end
            end
        end

        ndiscarded_d = ndiscarded_q + 16'(disc_trunc) + 16'(disc_frame);
    end

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            buf_we_q     <= 1'b0;
            buf_addr_q   <= '0;
            buf_wdata_q  <= '0;
            receiving_q  <= 1'b0;
            rx_size_q    <= '0;
            rx_wrote_q   <= '0;
            ndiscarded_q <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            buf_we_q     <= buf_we_d;
            buf_addr_q   <= buf_addr_d;
            buf_wdata_q  <= buf_wdata_d;
            receiving_q  <= receiving_d;
            rx_size_q    <= rx_size_d;
            rx_wrote_q   <= rx_wrote_d;
            ndiscarded_q <= ndiscarded_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign buf_we     = buf_we_q;
    assign buf_addr   = buf_addr_q;
    assign buf_wdata  = buf_wdata_q;
    assign receiving  = receiving_q;
    assign rx_size    = rx_size_q;
    assign rx_wrote   = rx_wrote_q;
    assign ndiscarded = ndiscarded_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_eth_rx_bufwriter.sv
// tb_eth_rx_bufwriter
// Directed bench for eth_rx_bufwriter: sends hand-built frames and checks
// buffer writes, commit/discard counters and reset behaviour against
// hand-computed values.

module tb_eth_rx_bufwriter;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_first;
    logic        in_last;
    logic        in_err;
    logic [15:0] rx_read;
    logic        buf_we;
    logic [31:0] buf_addr;
    logic [7:0]  buf_wdata;
    logic        receiving;
    logic [15:0] rx_size;
    logic [15:0] rx_wrote;
    logic [15:0] ndiscarded;
    logic        frame_done;

    int          checkCount = 0;
    int          errorCount = 0;
    int          wrIdx;
    int          wrCount;
    int          badCount;
    int          doneCount;
    logic [7:0]  curBase;

    eth_rx_bufwriter #(
        .MTU(1536),
        .AW(32),
        .MIN_LEN(14)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_first(in_first),
        .in_last(in_last),
        .in_err(in_err),
        .rx_read(rx_read),
        .buf_we(buf_we),
        .buf_addr(buf_addr),
        .buf_wdata(buf_wdata),
        .receiving(receiving),
        .rx_size(rx_size),
        .rx_wrote(rx_wrote),
        .ndiscarded(ndiscarded),
        .frame_done(frame_done)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // Watchdog so the run always ends even if something stalls.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Observe DUT outputs just after a clock edge: log writes and done pulses.
    task automatic sampleOutputs();
        logic [7:0] expData;
        if (buf_we) begin
            expData = curBase + 8'(wrIdx);
            wrCount++;
            if (buf_addr !== 32'(wrIdx) || buf_wdata !== expData)
                badCount++;
            wrIdx++;
        end
        if (frame_done)
            doneCount++;
    endtask

    // Drive one byte for one clock, then sample.
    task automatic sendByte(input logic [7:0] data, input logic first,
                            input logic last, input logic err);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = data;
        in_first = first;
        in_last  = last;
        in_err   = err;
        @(posedge clk);
        #1;
        sampleOutputs();
    endtask

    // One cycle with no valid byte, still sampling.
    task automatic idleCycle();
        @(negedge clk);
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
        in_err   = 1'b0;
        @(posedge clk);
        #1;
        sampleOutputs();
    endtask

    // Send bytes firstIdx..lastIdx of a len-byte frame with data base+i.
    task automatic applyStimulus(input int len, input int firstIdx, input int lastIdx,
                                 input logic errLast, input logic [7:0] base);
        curBase   = base;
        wrIdx     = firstIdx;
        wrCount   = 0;
        badCount  = 0;
        doneCount = 0;
        for (int i = firstIdx; i <= lastIdx; i++) begin
            sendByte(base + 8'(i), (i == 0), (i == len - 1), errLast && (i == len - 1));
        end
        idleCycle();
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_first = 1'b0;
        in_last  = 1'b0;
        in_err   = 1'b0;
        rx_read  = 16'h0000;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_buf_we", 32'(buf_we), 32'd0);
        checkOutput("rst_buf_addr", buf_addr, 32'd0);
        checkOutput("rst_receiving", 32'(receiving), 32'd0);
        checkOutput("rst_rx_size", 32'(rx_size), 32'd0);
        checkOutput("rst_rx_wrote", 32'(rx_wrote), 32'd0);
        checkOutput("rst_ndiscarded", 32'(ndiscarded), 32'd0);
        checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Normal 60-byte frame into a free buffer
        applyStimulus(60, 0, 59, 1'b0, 8'h00);
        checkOutput("f60_writes", 32'(wrCount), 32'd60);
        checkOutput("f60_bad_writes", 32'(badCount), 32'd0);
        checkOutput("f60_done", 32'(doneCount), 32'd1);
        checkOutput("f60_rx_size", 32'(rx_size), 32'd60);
        checkOutput("f60_rx_wrote", 32'(rx_wrote), 32'd1);
        checkOutput("f60_receiving", 32'(receiving), 32'd0);
        checkOutput("f60_ndiscarded", 32'(ndiscarded), 32'd0);

        // Buffer busy: frame dropped without writes
        applyStimulus(60, 0, 59, 1'b0, 8'h00);
        checkOutput("busy_writes", 32'(wrCount), 32'd0);
        checkOutput("busy_done", 32'(doneCount), 32'd0);
        checkOutput("busy_ndiscarded", 32'(ndiscarded), 32'd1);
        checkOutput("busy_rx_wrote", 32'(rx_wrote), 32'd1);
        checkOutput("busy_rx_size", 32'(rx_size), 32'd60);

        // Software caught up: 64-byte frame commits
        rx_read = 16'd1;
        applyStimulus(64, 0, 63, 1'b0, 8'h40);
        checkOutput("f64_writes", 32'(wrCount), 32'd64);
        checkOutput("f64_bad_writes", 32'(badCount), 32'd0);
        checkOutput("f64_done", 32'(doneCount), 32'd1);
        checkOutput("f64_rx_size", 32'(rx_size), 32'd64);
        checkOutput("f64_rx_wrote", 32'(rx_wrote), 32'd2);

        // Oversized frame: exactly MTU writes then dropped
        rx_read = 16'd2;
        applyStimulus(1600, 0, 1599, 1'b0, 8'h00);
        checkOutput("big_writes", 32'(wrCount), 32'd1536);
        checkOutput("big_bad_writes", 32'(badCount), 32'd0);
        checkOutput("big_done", 32'(doneCount), 32'd0);
        checkOutput("big_ndiscarded", 32'(ndiscarded), 32'd2);
        checkOutput("big_rx_wrote", 32'(rx_wrote), 32'd2);
        checkOutput("big_receiving", 32'(receiving), 32'd0);

        applyStimulus(100, 0, 99, 1'b0, 8'h10);
        checkOutput("f100_writes", 32'(wrCount), 32'd100);
        checkOutput("f100_bad_writes", 32'(badCount), 32'd0);
        checkOutput("f100_done", 32'(doneCount), 32'd1);
        checkOutput("f100_rx_size", 32'(rx_size), 32'd100);
        checkOutput("f100_rx_wrote", 32'(rx_wrote), 32'd3);

        // Runt frame and errored frame are both discarded
        rx_read = 16'd3;
        applyStimulus(10, 0, 9, 1'b0, 8'h20);
        checkOutput("runt_done", 32'(doneCount), 32'd0);
        checkOutput("runt_ndiscarded", 32'(ndiscarded), 32'd3);
        applyStimulus(64, 0, 63, 1'b1, 8'h30);
        checkOutput("err_done", 32'(doneCount), 32'd0);
        checkOutput("err_ndiscarded", 32'(ndiscarded), 32'd4);
        checkOutput("err_rx_wrote", 32'(rx_wrote), 32'd3);
        checkOutput("err_rx_size", 32'(rx_size), 32'd100);

        // Reset in the middle of a frame
        applyStimulus(60, 0, 29, 1'b0, 8'h00);
        checkOutput("mid_writes", 32'(wrCount), 32'd30);
        checkOutput("mid_receiving", 32'(receiving), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("mrst_receiving", 32'(receiving), 32'd0);
        checkOutput("mrst_rx_wrote", 32'(rx_wrote), 32'd0);
        checkOutput("mrst_ndiscarded", 32'(ndiscarded), 32'd0);
        checkOutput("mrst_rx_size", 32'(rx_size), 32'd0);
        checkOutput("mrst_buf_we", 32'(buf_we), 32'd0);
        rx_read = 16'd0;
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(60, 30, 59, 1'b0, 8'h00);
        checkOutput("stray_writes", 32'(wrCount), 32'd0);
        checkOutput("stray_done", 32'(doneCount), 32'd0);
        checkOutput("stray_ndiscarded", 32'(ndiscarded), 32'd0);
        checkOutput("stray_receiving", 32'(receiving), 32'd0);
        applyStimulus(60, 0, 59, 1'b0, 8'h55);
        checkOutput("post_writes", 32'(wrCount), 32'd60);
        checkOutput("post_bad_writes", 32'(badCount), 32'd0);
        checkOutput("post_done", 32'(doneCount), 32'd1);
        checkOutput("post_rx_wrote", 32'(rx_wrote), 32'd1);
        checkOutput("post_rx_size", 32'(rx_size), 32'd60);

        // Committed-frame counter wraps from 0xFFFF to 0
        @(negedge clk);
        force dut.rx_wrote_q = 16'hFFFF;
        @(negedge clk);
        release dut.rx_wrote_q;
        rx_read = 16'hFFFF;
        #1;
        checkOutput("preset_rx_wrote", 32'(rx_wrote), 32'hFFFF);
        applyStimulus(20, 0, 19, 1'b0, 8'hA0);
        checkOutput("wrap_done", 32'(doneCount), 32'd1);
        checkOutput("wrap_rx_wrote", 32'(rx_wrote), 32'd0);
        checkOutput("wrap_rx_size", 32'(rx_size), 32'd20);
        checkOutput("wrap_ndiscarded", 32'(ndiscarded), 32'd0);

        // One-byte frame is shorter than the header and gets discarded
        rx_read = 16'h0000;
        applyStimulus(1, 0, 0, 1'b0, 8'h77);
        checkOutput("one_done", 32'(doneCount), 32'd0);
        checkOutput("one_ndiscarded", 32'(ndiscarded), 32'd1);
        checkOutput("one_rx_wrote", 32'(rx_wrote), 32'd0);
        checkOutput("one_receiving", 32'(receiving), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
